// File: rtl/sipo_word_rx_if.sv
// Serial-in / word-out bundle for sipo_word_rx: serial input side, valid/ready word output side.
interface sipo_word_rx_if #(
  parameter int WIDTH = 8
) ();
  logic             en_sipo;
  logic             valid;
  logic             data_in;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             overrun;
  logic             parity_err;

  modport master (
    output en_sipo, valid, data_in, out_ready,
    input  data_out, out_valid, overrun, parity_err
  );

  modport slave (
    input  en_sipo, valid, data_in, out_ready,
    output data_out, out_valid, overrun, parity_err
  );
endinterface

// File: rtl/sipo_word_rx.sv
// WIDTH-bit serial-to-parallel receiver with a one-entry valid/ready output buffer and sticky overrun.
// Define SIPO_PARITY_EN to expect a trailing parity bit after each word and report parity_err.
module sipo_word_rx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  sipo_word_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] data_r;
  logic [CW-1:0]    cnt_r;
  logic             out_valid_r;
  logic             overrun_r;
  logic             parity_err_r;
  logic             sample_s;
  logic             in_par_s;
  logic             last_data_s;
  logic             push_s;
  logic             pop_s;
  logic             par_bad_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; dropping en_sipo always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!bus.en_sipo) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DATA: begin
          if (PAR_EN && last_data_s) begin
            state_nxt_s = PAR;
          end else begin
            state_nxt_s = DATA;
          end
        end
        PAR: begin
          if (sample_s) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = PAR;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output decode: sampling, shift direction, word completion and parity check
  always_comb begin
    sample_s    = bus.en_sipo & bus.valid;
    in_par_s    = (state_r == PAR);
    last_data_s = sample_s && !in_par_s && (cnt_r == LAST);
    pop_s       = out_valid_r & bus.out_ready;
    if (MSB_FIRST) begin
      shift_nxt_s = {shift_r[WIDTH-2:0], bus.data_in};
    end else begin
      shift_nxt_s = {bus.data_in, shift_r[WIDTH-1:1]};
    end
    if (in_par_s) begin
      // shift_r already holds the complete data word; this bit is parity only
      push_s    = sample_s;
      word_s    = shift_r;
      par_bad_s = ((^shift_r) ^ bus.data_in) != PARITY_ODD;
    end else begin
      push_s    = last_data_s && !PAR_EN;
      word_s    = shift_nxt_s;
      par_bad_s = 1'b0;
    end
  end

  // Shift register and bit counter; cleared whenever the block is disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (!bus.en_sipo) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (sample_s && !in_par_s) begin
      shift_r <= shift_nxt_s;
      cnt_r   <= (cnt_r == LAST) ? {CW{1'b0}} : (cnt_r + CW'(1));
    end
  end

  // Output buffer: a completing word may replace the one being consumed in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r       <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else if (push_s && (!out_valid_r || bus.out_ready)) begin
      data_r       <= word_s;
      out_valid_r  <= 1'b1;
      parity_err_r <= par_bad_s;
    end else if (pop_s) begin
      out_valid_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end
  end

  // Sticky overrun, cleared only by reset or disabling the block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r <= 1'b0;
    end else if (!bus.en_sipo) begin
      overrun_r <= 1'b0;
    end else if (push_s && out_valid_r && !bus.out_ready) begin
      overrun_r <= 1'b1;
    end
  end

  assign bus.data_out   = data_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.overrun    = overrun_r;
  assign bus.parity_err = parity_err_r;

endmodule
